// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the fetch unit's program-memory bus and its ALU-facing signals.
//   PM_ADDR      program memory address (= PC)
//   PM_DATA      program memory read data, combinational, valid by Q4
//   PCL_WE       ALU wrote PCL this instruction cycle (sampled at Q4)
//   PCL_DATA     value written to PCL
//   PCLATH       PCLATH[4:0] from the register file
//   SKIP_REQ     ALU skip result (sampled at Q4)
//   OP_CODE      instruction in execute, to ALU
//   Q_PHASE      0=Q1 .. 3=Q4
//   INSTR_VALID  1 = OP_CODE is a fetched instruction, 0 = bubble
//   RETFIE_SET   one-clk pulse at Q4 when RETFIE retires
//   STK_OVF      sticky stack overflow (0 unless STACK_FLAGS_EN)
//   STK_UNF      sticky stack underflow (0 unless STACK_FLAGS_EN)
// Modports: master = fetch unit, slave = program memory / ALU side.
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int PC_WIDTH = 13
);
    logic [PC_WIDTH-1:0] PM_ADDR;
    logic [13:0]         PM_DATA;
    logic                PCL_WE;
    logic [7:0]          PCL_DATA;
    logic [4:0]          PCLATH;
    logic                SKIP_REQ;
    logic [13:0]         OP_CODE;
    logic [1:0]          Q_PHASE;
    logic                INSTR_VALID;
    logic                RETFIE_SET;
    logic                STK_OVF;
    logic                STK_UNF;

    modport master (
        output PM_ADDR, OP_CODE, Q_PHASE, INSTR_VALID, RETFIE_SET, STK_OVF, STK_UNF,
        input  PM_DATA, PCL_WE, PCL_DATA, PCLATH, SKIP_REQ
    );

    modport slave (
        input  PM_ADDR, OP_CODE, Q_PHASE, INSTR_VALID, RETFIE_SET, STK_OVF, STK_UNF,
        output PM_DATA, PCL_WE, PCL_DATA, PCLATH, SKIP_REQ
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch/decode stage feeding the ALU. Owns the PC, the circular hardware
// return stack, the Q1..Q4 phase counter and the instruction register.
// Fetch of PC overlaps execute of OP_CODE; GOTO/CALL/RETURN/RETLW/RETFIE,
// PCL writes and skips replace the prefetched word with a NOP bubble.
//
// Ports:
//   clk    system clock, one instruction cycle = 4 clk
//   rst_n  synchronous active-low reset
//   bus    instr_fetch_unit_if.master (program memory + ALU signals)
//
// Build option: define STACK_FLAGS_EN to build the stack occupancy counter
// that drives sticky STK_OVF / STK_UNF; otherwise both are tied to 0.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int          PC_WIDTH    = 13,
    parameter int          STACK_DEPTH = 8,
    parameter logic [13:0] NOP_CODE    = 14'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);

    localparam int SP_W = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } phase_t;

    phase_t              phase_q, phase_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [13:0]         ir_q, ir_d;
    logic                valid_q, valid_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic                push, pop;
    logic                is_goto, is_call, is_ret, is_retfie;
    logic [PC_WIDTH-1:0] pc_inc, goto_tgt, pcl_tgt, pop_tgt;
    logic [SP_W-1:0]     sp_dec;

    // ------------------------------------------------------------------
    // Decode of the instruction in execute. Bubbles never branch, so every
    // control decode is qualified by valid_q.
    // ------------------------------------------------------------------
    assign is_goto   = valid_q && (ir_q[13:11] == 3'b101);
    assign is_call   = valid_q && (ir_q[13:11] == 3'b100);
    assign is_retfie = valid_q && (ir_q == 14'h0009);
    assign is_ret    = valid_q && ((ir_q == 14'h0008) || (ir_q[13:10] == 4'b1101) ||
                                   (ir_q == 14'h0009));

    // PC increments wrap naturally at 2^PC_WIDTH.
    assign pc_inc   = pc_q + PC_WIDTH'(1);
    assign goto_tgt = PC_WIDTH'({bus.PCLATH[4:3], ir_q[10:0]});
    assign pcl_tgt  = PC_WIDTH'({bus.PCLATH, bus.PCL_DATA});
    // Pop pre-decrements SP; the 3-bit SP wraps so popping empty reads the top entry.
    assign sp_dec   = sp_q - SP_W'(1);
    assign pop_tgt  = stack_q[sp_dec];

    // ------------------------------------------------------------------
    // Phase counter: Q1 -> Q2 -> Q3 -> Q4 -> Q1 ...
    // ------------------------------------------------------------------
    always_comb begin
        phase_d = Q1;
        case (phase_q)
            Q1:      phase_d = Q2;
            Q2:      phase_d = Q3;
            Q3:      phase_d = Q4;
            Q4:      phase_d = Q1;
            default: phase_d = Q1;
        endcase
    end

    // ------------------------------------------------------------------
    // Q4-edge update: exactly one action, in priority order.
    // ------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        sp_d    = sp_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (phase_q == Q4) begin
            // Every branch except the default inserts a bubble.
            ir_d    = NOP_CODE;
            valid_d = 1'b0;
            if (is_goto) begin
                pc_d = goto_tgt;
            end else if (is_call) begin
                // PC already points past the CALL, so it is the return address.
                push = 1'b1;
                sp_d = sp_q + SP_W'(1);
                pc_d = goto_tgt;
            end else if (is_ret) begin
                pop  = 1'b1;
                sp_d = sp_dec;
                pc_d = pop_tgt;
            end else if (bus.PCL_WE) begin
                pc_d = pcl_tgt;
            end else if (bus.SKIP_REQ) begin
                pc_d = pc_inc;
            end else begin
                ir_d    = bus.PM_DATA;
                valid_d = 1'b1;
                pc_d    = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= Q1;
            pc_q    <= '0;
            ir_q    <= NOP_CODE;
            valid_q <= 1'b0;
            sp_q    <= '0;
        end else begin
            phase_q <= phase_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            sp_q    <= sp_d;
        end
    end

    // Return stack: circular, a push past the top overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push) begin
            stack_q[sp_q] <= pc_q;
        end
    end

`ifdef STACK_FLAGS_EN
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    logic [CNT_W-1:0] occ_q;
    logic             ovf_q, unf_q;

    // Occupancy saturates at 0 and STACK_DEPTH; the flags record any attempt
    // to go beyond and stay set until reset. The SP itself still wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (push) begin
            if (occ_q == CNT_W'(STACK_DEPTH)) begin
                ovf_q <= 1'b1;
            end else begin
                occ_q <= occ_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (occ_q == '0) begin
                unf_q <= 1'b1;
            end else begin
                occ_q <= occ_q - CNT_W'(1);
            end
        end
    end

    assign bus.STK_OVF = ovf_q;
    assign bus.STK_UNF = unf_q;
`else
    assign bus.STK_OVF = 1'b0;
    assign bus.STK_UNF = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.PM_ADDR     = pc_q;
    assign bus.OP_CODE     = ir_q;
    assign bus.INSTR_VALID = valid_q;
    assign bus.Q_PHASE     = phase_q;
    assign bus.RETFIE_SET  = (phase_q == Q4) && is_retfie;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. The bench models program memory and
// plays the ALU (PCL_WE / PCLATH / SKIP_REQ). All expected values are
// hand-derived from the program image loaded below.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

`ifdef STACK_FLAGS_EN
    localparam logic FLAGS_ON = 1'b1;
`else
    localparam logic FLAGS_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   failed;

    logic [13:0] pm [0:8191];

    instr_fetch_unit_if #(.PC_WIDTH(13)) ifc ();

    instr_fetch_unit #(
        .PC_WIDTH    (13),
        .STACK_DEPTH (8),
        .NOP_CODE    (14'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    assign ifc.PM_DATA = pm[ifc.PM_ADDR];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        repeat (4) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One line per instruction cycle: address being fetched, instruction in execute.
    task automatic check_cycle(input string tag, input logic [12:0] addr,
                               input logic [13:0] op, input logic vld);
        $display("%s: PM_ADDR=0x%04h OP_CODE=0x%04h VALID=%0b", tag,
                 ifc.PM_ADDR, ifc.OP_CODE, ifc.INSTR_VALID);
        check({tag, ".addr"},  32'(ifc.PM_ADDR),     32'(addr));
        check({tag, ".op"},    32'(ifc.OP_CODE),     32'(op));
        check({tag, ".valid"}, 32'(ifc.INSTR_VALID), 32'(vld));
    endtask

    function automatic logic [12:0] ret_land(input int r);
        // Nine calls from 0x200,0x210..0x280 leave entry0=0x281, entries1..7=0x211..0x271.
        // Pops 1..8 walk 0x281,0x271..0x211; pop 9 wraps back to entry0 = 0x281.
        if (r == 9) return 13'h281;
        return 13'(32'h291 - 32'h10 * r);
    endfunction

    initial begin
        logic [12:0] caddr, ctgt, raddr;
        logic [13:0] rop;

        total  = 0;
        passed = 0;
        failed = 0;

        for (int i = 0; i < 8192; i++) pm[i] = 14'h0000;
        pm[13'h000] = 14'h3095;   // MOVLW
        pm[13'h001] = 14'h0080;   // MOVWF
        pm[13'h002] = 14'h3001;
        pm[13'h003] = 14'h2805;   // GOTO 5
        pm[13'h004] = 14'h3004;   // never executed
        pm[13'h005] = 14'h2010;   // CALL 0x10
        pm[13'h006] = 14'h3006;
        pm[13'h007] = 14'h3007;   // ALU skips here
        pm[13'h008] = 14'h3008;   // skipped
        pm[13'h009] = 14'h3009;   // ALU writes PCL here
        pm[13'h010] = 14'h0008;   // RETURN
        pm[13'h120] = 14'h2FFF;   // GOTO 0x7FF with PCLATH=0x18 -> 0x1FFF
        pm[13'h1FFF] = 14'h3FFF;  // last word; ALU writes PCL -> 0x200
        for (int j = 0; j < 9; j++) pm[13'h200 + 13'(16 * j)] = 14'h2210 + 14'(16 * j);
        pm[13'h290] = 14'h0009;   // RETFIE
        pm[13'h281] = 14'h3455;   // RETLW 0x55
        for (int j = 0; j < 7; j++) pm[13'h211 + 13'(16 * j)] = 14'h0008;

        rst_n        = 1'b0;
        ifc.PCL_WE   = 1'b0;
        ifc.PCL_DATA = 8'h00;
        ifc.PCLATH   = 5'h00;
        ifc.SKIP_REQ = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.q_phase", 32'(ifc.Q_PHASE),    32'd0);
        check("rst.retfie",  32'(ifc.RETFIE_SET), 32'd0);
        check("rst.ovf",     32'(ifc.STK_OVF),    32'd0);
        check("rst.unf",     32'(ifc.STK_UNF),    32'd0);
        rst_n = 1'b1;

        // Cycle 1: bubble while fetching address 0; phases count up.
        check_cycle("c1", 13'h000, 14'h0000, 1'b0);
        for (int p = 1; p < 4; p++) begin
            tick();
            check("c1.q_phase", 32'(ifc.Q_PHASE), 32'(p));
            check("c1.addr_hold", 32'(ifc.PM_ADDR), 32'h0);
        end
        tick();
        check("c2.q_phase", 32'(ifc.Q_PHASE), 32'd0);
        // Cycle 2: OP_CODE stable over all four phases.
        check_cycle("c2", 13'h001, 14'h3095, 1'b1);
        for (int p = 1; p < 4; p++) begin
            tick();
            check("c2.op_stable", 32'(ifc.OP_CODE), 32'h3095);
        end
        tick();
        check_cycle("c3", 13'h002, 14'h0080, 1'b1); next_cycle();
        check_cycle("c4", 13'h003, 14'h3001, 1'b1); next_cycle();
        check_cycle("c5_goto", 13'h004, 14'h2805, 1'b1); next_cycle();
        check_cycle("c6_bubble", 13'h005, 14'h0000, 1'b0); next_cycle();
        check_cycle("c7_call", 13'h006, 14'h2010, 1'b1); next_cycle();
        check_cycle("c8_bubble", 13'h010, 14'h0000, 1'b0); next_cycle();
        check_cycle("c9_return", 13'h011, 14'h0008, 1'b1); next_cycle();
        check_cycle("c10_bubble", 13'h006, 14'h0000, 1'b0); next_cycle();
        check_cycle("c11", 13'h007, 14'h3006, 1'b1); next_cycle();

        check_cycle("c12_skip", 13'h008, 14'h3007, 1'b1);
        ifc.SKIP_REQ = 1'b1;
        next_cycle();
        ifc.SKIP_REQ = 1'b0;
        check_cycle("c13_skipped", 13'h009, 14'h0000, 1'b0); next_cycle();

        check_cycle("c14_pclwr", 13'h00A, 14'h3009, 1'b1);
        ifc.PCL_WE   = 1'b1;
        ifc.PCL_DATA = 8'h20;
        ifc.PCLATH   = 5'h01;
        next_cycle();
        ifc.PCL_WE = 1'b0;
        ifc.PCLATH = 5'h18;
        check_cycle("c15_bubble", 13'h120, 14'h0000, 1'b0); next_cycle();
        check_cycle("c16_goto_hi", 13'h121, 14'h2FFF, 1'b1); next_cycle();
        ifc.PCLATH = 5'h00;
        check_cycle("c17_bubble", 13'h1FFF, 14'h0000, 1'b0); next_cycle();

        // PC wrapped from 0x1FFF to 0x0000; PCL write escapes to 0x200.
        check_cycle("c18_wrap", 13'h0000, 14'h3FFF, 1'b1);
        ifc.PCL_WE   = 1'b1;
        ifc.PCL_DATA = 8'h00;
        ifc.PCLATH   = 5'h02;
        next_cycle();
        ifc.PCL_WE = 1'b0;
        ifc.PCLATH = 5'h00;
        check_cycle("c19_bubble", 13'h200, 14'h0000, 1'b0); next_cycle();

        // Nine nested CALLs.
        for (int k = 1; k <= 9; k++) begin
            caddr = 13'h200 + 13'(16 * (k - 1));
            ctgt  = caddr + 13'h010;
            check_cycle($sformatf("call%0d", k), caddr + 13'h001, 14'h2000 | 14'(ctgt), 1'b1);
            next_cycle();
            check_cycle($sformatf("call%0d_bubble", k), ctgt, 14'h0000, 1'b0);
            if (k == 8) check("ovf_after_call8", 32'(ifc.STK_OVF), 32'd0);
            if (k == 9) check("ovf_after_call9", 32'(ifc.STK_OVF), 32'(FLAGS_ON));
            next_cycle();
        end

        // Nine returns: RETFIE, RETLW, then seven RETURNs.
        for (int r = 1; r <= 9; r++) begin
            raddr = (r == 1) ? 13'h290 : ret_land(r - 1);
            rop   = (r == 1) ? 14'h0009 : ((r == 2) ? 14'h3455 : 14'h0008);
            check_cycle($sformatf("ret%0d", r), raddr + 13'h001, rop, 1'b1);
            if (r == 1) begin
                check("retfie_q1", 32'(ifc.RETFIE_SET), 32'd0);
                repeat (3) tick();
                check("retfie_q4", 32'(ifc.RETFIE_SET), 32'd1);
                tick();
                check("retfie_after", 32'(ifc.RETFIE_SET), 32'd0);
            end else begin
                next_cycle();
            end
            check_cycle($sformatf("ret%0d_bubble", r), ret_land(r), 14'h0000, 1'b0);
            if (r == 8) check("unf_after_ret8", 32'(ifc.STK_UNF), 32'd0);
            if (r == 9) check("unf_after_ret9", 32'(ifc.STK_UNF), 32'(FLAGS_ON));
            if (r < 9) next_cycle();
        end

        // Reset at Q3 aborts the pending Q4 update and clears the flags.
        tick();
        tick();
        check("pre_rst.q_phase", 32'(ifc.Q_PHASE), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2.q_phase", 32'(ifc.Q_PHASE), 32'd0);
        check("rst2.ovf", 32'(ifc.STK_OVF), 32'd0);
        check("rst2.unf", 32'(ifc.STK_UNF), 32'd0);
        check_cycle("rst2.c1", 13'h000, 14'h0000, 1'b0);
        next_cycle();
        check_cycle("rst2.c2", 13'h001, 14'h3095, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
